// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//
// Shared definitions for the multiply/divide unit.
//   ITER        : number of iteration cycles per operation (one per bit)
//   DATA_W      : operand / result width
//   op_e        : operation encoding as presented on the op port
//   state_e     : control state encoding
//   isDivOp     : true for the two operations that run the divider
//   selectResult: picks the architectural result out of the final
//                 16-bit working register for a given operation
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int unsigned ITER   = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_MULLO = 2'd0,
        OP_MULHI = 2'd1,
        OP_DIV   = 2'd2,
        OP_REM   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Divide and remainder share the restoring-division datapath.
    function automatic logic isDivOp(input op_e opSel);
        return (opSel == OP_DIV) || (opSel == OP_REM);
    endfunction

    // The working register holds {product_hi, product_lo} after a multiply
    // and {remainder, quotient} after a divide.
    function automatic logic [7:0] selectResult(input op_e opSel,
                                                input logic [15:0] workReg);
        logic [7:0] sel;
        case (opSel)
            OP_MULLO: sel = workReg[7:0];
            OP_MULHI: sel = workReg[15:8];
            OP_DIV:   sel = workReg[7:0];
            OP_REM:   sel = workReg[15:8];
            default:  sel = 8'h00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative 8-bit unsigned multiply / divide unit feeding a register-file
// write port. One operation takes 8 iteration cycles plus one DONE cycle.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : asynchronous active-high reset
//   start     : request a new operation, only looked at while idle
//   op        : 0 MULLO, 1 MULHI, 2 DIV (quotient), 3 REM (remainder)
//   a_in/b_in : unsigned operands from register-file read ports A and B
//   dst_in    : destination register pointer
//   busy      : high while an operation is running or finishing
//   done      : one-cycle pulse when result is valid
//   result    : selected result, held until the next accepted start
//   wr_en     : register-file write enable (identical to done)
//   wr_addr   : register-file write address
//   div_zero  : divide by zero flag for DIV/REM, held with result
// ---------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int pw = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [7:0]    a_in,
    input  logic [7:0]    b_in,
    input  logic [pw-1:0] dst_in,
    output logic          busy,
    output logic          done,
    output logic [7:0]    result,
    output logic          wr_en,
    output logic [pw-1:0] wr_addr,
    output logic          div_zero
);

    localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

    // Control state
    state_e        state_q;
    logic [3:0]    count_q;
    logic [3:0]    count_d;
    logic          busy_q;
    logic          done_q;

    // Latched operation
    op_e           op_q;
    logic [7:0]    b_q;
    logic [pw-1:0] dst_q;

    // Shared working register: {hi, lo}
    logic [15:0]   shiftReg_q;
    logic [15:0]   shiftReg_d;

    // Registered outputs
    logic [7:0]    result_q;
    logic [pw-1:0] wrAddr_q;
    logic          divZero_q;

    // Shared adder/subtractor signals
    logic          opIsDiv;
    logic [7:0]    addA;
    logic [7:0]    addB;
    logic          addCin;
    logic [8:0]    sum;
    logic          divFits;

    // Operand selection for the single 8-bit adder/subtractor.
    // Multiply: add b to the high half when the current multiplier bit
    // (LSB of the low half) is set.
    // Divide: subtract b from the partial remainder formed by shifting the
    // working register left by one; this is done as a + ~b + 1 so the carry
    // out doubles as a "no borrow" indicator.
    always_comb begin
        opIsDiv = isDivOp(op_q);
        addA    = shiftReg_q[15:8];
        addB    = 8'h00;
        addCin  = 1'b0;
        if (opIsDiv) begin
            addA   = shiftReg_q[14:7];
            addB   = ~b_q;
            addCin = 1'b1;
        end else if (shiftReg_q[0]) begin
            addB   = b_q;
        end
        sum = {1'b0, addA} + {1'b0, addB} + {8'h00, addCin};
    end

    // Next value of the working register for one iteration.
    // The shifted partial remainder is 9 bits wide; its top bit is the bit
    // leaving shiftReg_q[15]. If that bit is set the partial remainder is
    // at least 256 and therefore always fits b, otherwise the adder carry
    // tells whether the subtraction stayed non-negative. With b = 0 every
    // step fits, which naturally produces quotient 0xFF and remainder a.
    always_comb begin
        divFits    = shiftReg_q[15] | sum[8];
        shiftReg_d = shiftReg_q;
        if (opIsDiv) begin
            shiftReg_d = {(divFits ? sum[7:0] : shiftReg_q[14:7]),
                          shiftReg_q[6:0], divFits};
        end else begin
            shiftReg_d = {sum, shiftReg_q[7:1]};
        end
        count_d = count_q + 4'd1;
    end

    // Control FSM with registered outputs.
    // IDLE accepts start and loads the operands; a_in goes straight into
    // the low half of the working register since both the multiplier and
    // the dividend are consumed from there. RUN performs one iteration per
    // cycle and on the last one captures the result, write address and
    // divide-by-zero flag. DONE lasts exactly one cycle and ignores start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            op_q       <= OP_MULLO;
            b_q        <= 8'h00;
            dst_q      <= '0;
            shiftReg_q <= 16'h0000;
            result_q   <= 8'h00;
            wrAddr_q   <= '0;
            divZero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q       <= op_e'(op);
                        b_q        <= b_in;
                        dst_q      <= dst_in;
                        shiftReg_q <= {8'h00, a_in};
                        count_q    <= 4'd0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    shiftReg_q <= shiftReg_d;
                    count_q    <= count_d;
                    if (count_q == LAST_ITER) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        result_q  <= selectResult(op_q, shiftReg_d);
                        wrAddr_q  <= dst_q;
                        divZero_q <= opIsDiv && (b_q == 8'h00);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_en    = done_q;
    assign result   = result_q;
    assign wr_addr  = wrAddr_q;
    assign div_zero = divZero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit. Inputs are driven and outputs are
// sampled on the falling clock edge. Expected values come from a plain
// arithmetic reference model (*, /, %).
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [2:0] dst_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic       div_zero;

    int assertions = 0;
    int failures   = 0;

    muldiv_unit #(.pw(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .dst_in   (dst_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .div_zero (div_zero)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: returns {div_zero, result} from plain arithmetic.
    function automatic logic [8:0] refModel(input logic [1:0] opV,
                                            input logic [7:0] aV,
                                            input logic [7:0] bV);
        int unsigned prod;
        logic [15:0] prod16;
        prod   = int'(aV) * int'(bV);
        prod16 = prod[15:0];
        case (opV)
            2'd0:    return {1'b0, prod16[7:0]};
            2'd1:    return {1'b0, prod16[15:8]};
            2'd2:    return (bV == 8'h00) ? {1'b1, 8'hFF} : {1'b0, 8'(aV / bV)};
            default: return (bV == 8'h00) ? {1'b1, aV} : {1'b0, 8'(aV % bV)};
        endcase
    endfunction

    // Runs one operation starting at the current falling edge. Latency is the
    // number of rising edges from the one that samples start up to and
    // including the one that raises done. Returns at the falling edge after
    // the done cycle, so an immediate next call starts on the first idle cycle.
    task automatic applyStimulus(input  logic [1:0] opV,
                                 input  logic [7:0] aV,
                                 input  logic [7:0] bV,
                                 input  logic [2:0] dstV,
                                 output bit         gotDone,
                                 output int         latency,
                                 output logic [7:0] res,
                                 output logic       wrEn,
                                 output logic [2:0] wrA,
                                 output logic       dz,
                                 output logic       postDone,
                                 output logic       postBusy,
                                 output logic [7:0] postRes);
        op     = opV;
        a_in   = aV;
        b_in   = bV;
        dst_in = dstV;
        start  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        a_in    = $urandom();
        b_in    = $urandom();
        latency = 1;
        while (done !== 1'b1 && latency < 20) begin
            @(negedge clk);
            latency++;
        end
        gotDone = (done === 1'b1);
        res     = result;
        wrEn    = wr_en;
        wrA     = wr_addr;
        dz      = div_zero;
        @(negedge clk);
        postDone = done;
        postBusy = busy;
        postRes  = result;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        a_in   = 8'h00;
        b_in   = 8'h00;
        dst_in = 3'd0;
        repeat (3) @(negedge clk);
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        assertions++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b required 0", done); end
        assertions++;
        if (wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en: got %b required 0", wr_en); end
        assertions++;
        if (result !== 8'h00) begin failures++; $display("[TB] FAIL reset_result: got %h required 00", result); end
        assertions++;
        if (wr_addr !== 3'd0) begin failures++; $display("[TB] FAIL reset_wr_addr: got %0d required 0", wr_addr); end
        assertions++;
        if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_div_zero: got %b required 0", div_zero); end
        reset = 1'b0;
    endtask

    // Called right after reset release: start is sampled on the first edge.
    task automatic test_mullo_basic();
        bit gd; int lat; logic [7:0] r, pr; logic we, dz, pd, pb; logic [2:0] wa;
        applyStimulus(2'd0, 8'd13, 8'd11, 3'd5, gd, lat, r, we, wa, dz, pd, pb, pr);
        assertions++;
        if (gd !== 1'b1) begin failures++; $display("[TB] FAIL mullo_done: got %b required 1", gd); end
        assertions++;
        if (lat !== 9) begin failures++; $display("[TB] FAIL mullo_latency: got %0d required 9", lat); end
        assertions++;
        if (r !== 8'h8F) begin failures++; $display("[TB] FAIL mullo_result: got %h required 8f", r); end
        assertions++;
        if (we !== 1'b1) begin failures++; $display("[TB] FAIL mullo_wr_en: got %b required 1", we); end
        assertions++;
        if (wa !== 3'd5) begin failures++; $display("[TB] FAIL mullo_wr_addr: got %0d required 5", wa); end
        assertions++;
        if (dz !== 1'b0) begin failures++; $display("[TB] FAIL mullo_div_zero: got %b required 0", dz); end
        assertions++;
        if (pd !== 1'b0 || pb !== 1'b0) begin failures++; $display("[TB] FAIL mullo_after: got done=%b busy=%b required 0 0", pd, pb); end
        assertions++;
        if (pr !== 8'h8F) begin failures++; $display("[TB] FAIL mullo_hold: got %h required 8f", pr); end
    endtask

    task automatic test_mul_ff();
        bit gd; int lat; logic [7:0] r, pr; logic we, dz, pd, pb; logic [2:0] wa;
        applyStimulus(2'd1, 8'hFF, 8'hFF, 3'd1, gd, lat, r, we, wa, dz, pd, pb, pr);
        assertions++;
        if (gd !== 1'b1 || r !== 8'hFE) begin failures++; $display("[TB] FAIL mulhi_ff: got done=%b result=%h required 1 fe", gd, r); end
        assertions++;
        if (dz !== 1'b0) begin failures++; $display("[TB] FAIL mulhi_div_zero: got %b required 0", dz); end
        applyStimulus(2'd0, 8'hFF, 8'hFF, 3'd2, gd, lat, r, we, wa, dz, pd, pb, pr);
        assertions++;
        if (gd !== 1'b1 || r !== 8'h01) begin failures++; $display("[TB] FAIL mullo_ff: got done=%b result=%h required 1 01", gd, r); end
    endtask

    task automatic test_div();
        bit gd; int lat; logic [7:0] r, pr; logic we, dz, pd, pb; logic [2:0] wa;
        applyStimulus(2'd2, 8'd200, 8'd7, 3'd3, gd, lat, r, we, wa, dz, pd, pb, pr);
        assertions++;
        if (gd !== 1'b1 || r !== 8'h1C) begin failures++; $display("[TB] FAIL div_200_7: got done=%b result=%h required 1 1c", gd, r); end
        assertions++;
        if (dz !== 1'b0) begin failures++; $display("[TB] FAIL div_200_7_dz: got %b required 0", dz); end
        applyStimulus(2'd3, 8'd200, 8'd7, 3'd4, gd, lat, r, we, wa, dz, pd, pb, pr);
        assertions++;
        if (gd !== 1'b1 || r !== 8'h04) begin failures++; $display("[TB] FAIL rem_200_7: got done=%b result=%h required 1 04", gd, r); end
        assertions++;
        if (dz !== 1'b0) begin failures++; $display("[TB] FAIL rem_200_7_dz: got %b required 0", dz); end
    endtask

    task automatic test_div_zero();
        bit gd; int lat; logic [7:0] r, pr; logic we, dz, pd, pb; logic [2:0] wa;
        applyStimulus(2'd2, 8'h2A, 8'h00, 3'd6, gd, lat, r, we, wa, dz, pd, pb, pr);
        assertions++;
        if (gd !== 1'b1 || r !== 8'hFF) begin failures++; $display("[TB] FAIL div_zero_q: got done=%b result=%h required 1 ff", gd, r); end
        assertions++;
        if (dz !== 1'b1) begin failures++; $display("[TB] FAIL div_zero_flag: got %b required 1", dz); end
        assertions++;
        if (lat !== 9) begin failures++; $display("[TB] FAIL div_zero_latency: got %0d required 9", lat); end
        applyStimulus(2'd3, 8'h2A, 8'h00, 3'd7, gd, lat, r, we, wa, dz, pd, pb, pr);
        assertions++;
        if (gd !== 1'b1 || r !== 8'h2A) begin failures++; $display("[TB] FAIL rem_zero_r: got done=%b result=%h required 1 2a", gd, r); end
        assertions++;
        if (dz !== 1'b1) begin failures++; $display("[TB] FAIL rem_zero_flag: got %b required 1", dz); end
        assertions++;
        if (wa !== 3'd7) begin failures++; $display("[TB] FAIL rem_zero_wr_addr: got %0d required 7", wa); end
    endtask

    // A second request with different operands is pulsed at run cycles 3
    // and 8 and again during the done cycle; none of them may be taken.
    task automatic test_start_ignored();
        int doneCount = 0;
        logic [7:0] r = 8'h00;
        logic [2:0] wa = 3'd0;
        op     = 2'd0;
        a_in   = 8'h21;
        b_in   = 8'h07;
        dst_in = 3'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (done === 1'b1) begin
                doneCount++;
                r  = result;
                wa = wr_addr;
            end
            if (cyc == 3 || cyc == 8 || cyc == 9) begin
                start  = 1'b1;
                op     = 2'd1;
                a_in   = 8'hFF;
                b_in   = 8'hFF;
                dst_in = 3'd6;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
        end
        assertions++;
        if (doneCount !== 1) begin failures++; $display("[TB] FAIL ignore_done_count: got %0d required 1", doneCount); end
        assertions++;
        if (r !== 8'hE7) begin failures++; $display("[TB] FAIL ignore_result: got %h required e7", r); end
        assertions++;
        if (wa !== 3'd3) begin failures++; $display("[TB] FAIL ignore_wr_addr: got %0d required 3", wa); end
        assertions++;
        if (busy !== 1'b0 || result !== 8'hE7) begin failures++; $display("[TB] FAIL ignore_after: got busy=%b result=%h required 0 e7", busy, result); end
    endtask

    task automatic test_reset_abort();
        int wrCount = 0;
        bit gd; int lat; logic [7:0] r, pr; logic we, dz, pd, pb; logic [2:0] wa;
        op     = 2'd0;
        a_in   = 8'h11;
        b_in   = 8'h0F;
        dst_in = 3'd7;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        assertions++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before: got %b required 1", busy); end
        reset = 1'b1;
        #1;
        assertions++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
            failures++; $display("[TB] FAIL abort_ctrl: got busy=%b done=%b wr_en=%b required 0 0 0", busy, done, wr_en);
        end
        assertions++;
        if (result !== 8'h00) begin failures++; $display("[TB] FAIL abort_result: got %h required 00", result); end
        assertions++;
        if (wr_addr !== 3'd0 || div_zero !== 1'b0) begin
            failures++; $display("[TB] FAIL abort_addr_dz: got wr_addr=%0d div_zero=%b required 0 0", wr_addr, div_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (wr_en === 1'b1) wrCount++;
            @(negedge clk);
        end
        assertions++;
        if (wrCount !== 0) begin failures++; $display("[TB] FAIL abort_no_wr_en: got %0d pulses required 0", wrCount); end
        applyStimulus(2'd0, 8'd3, 8'd5, 3'd2, gd, lat, r, we, wa, dz, pd, pb, pr);
        assertions++;
        if (gd !== 1'b1 || r !== 8'h0F || lat !== 9) begin
            failures++; $display("[TB] FAIL abort_then_mullo: got done=%b result=%h latency=%0d required 1 0f 9", gd, r, lat);
        end
    endtask

    // Consecutive operations, each started on the first idle cycle.
    task automatic test_back_to_back();
        bit gd; int lat; logic [7:0] r, pr; logic we, dz, pd, pb; logic [2:0] wa;
        logic [1:0] opV;
        logic [7:0] aV, bV;
        logic [8:0] exp;
        for (int i = 0; i < 4; i++) begin
            opV = 2'(i);
            aV  = 8'(8'd37 + 8'(i * 29));
            bV  = 8'(8'd9 + 8'(i * 3));
            exp = refModel(opV, aV, bV);
            applyStimulus(opV, aV, bV, 3'(i), gd, lat, r, we, wa, dz, pd, pb, pr);
            assertions++;
            if (gd !== 1'b1 || lat !== 9 || r !== exp[7:0]) begin
                failures++; $display("[TB] FAIL b2b_%0d: got done=%b latency=%0d result=%h required 1 9 %h", i, gd, lat, r, exp[7:0]);
            end
        end
    endtask

    task automatic test_random();
        bit gd; int lat; logic [7:0] r, pr; logic we, dz, pd, pb; logic [2:0] wa;
        logic [1:0] opV;
        logic [7:0] aV, bV;
        logic [2:0] dstV;
        logic [8:0] exp;
        for (int i = 0; i < 40; i++) begin
            opV  = 2'($urandom_range(0, 3));
            aV   = 8'($urandom());
            bV   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
            dstV = 3'($urandom());
            exp  = refModel(opV, aV, bV);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(opV, aV, bV, dstV, gd, lat, r, we, wa, dz, pd, pb, pr);
            assertions++;
            if (gd !== 1'b1 || lat !== 9) begin
                failures++; $display("[TB] FAIL rand_%0d_timing: got done=%b latency=%0d required 1 9", i, gd, lat);
            end
            assertions++;
            if (r !== exp[7:0] || dz !== exp[8]) begin
                failures++; $display("[TB] FAIL rand_%0d_value: op=%0d a=%h b=%h got result=%h dz=%b required %h %b",
                                     i, opV, aV, bV, r, dz, exp[7:0], exp[8]);
            end
            assertions++;
            if (wa !== dstV || we !== 1'b1 || pr !== exp[7:0]) begin
                failures++; $display("[TB] FAIL rand_%0d_write: got wr_addr=%0d wr_en=%b held=%h required %0d 1 %h",
                                     i, wa, we, pr, dstV, exp[7:0]);
            end
        end
    endtask

    initial begin
        $display("[TB] starting muldiv_unit tests");
        test_reset();
        test_mullo_basic();
        test_mul_ff();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
